// File: rtl/gpout_console_arbiter.sv
// Purpose: round-robin sequencer of a character FIFO and a status port onto the 16-bit GPOUT console bus.
// Latency: char accepted at E0 -> data at E1, strobe rises E1+SETUP, transfer period SETUP+STROBE+HOLD+1 cycles.
// Backpressure: CH_READY low while the FIFO is full or after end-of-test; ST_READY low while a code is pending or after end-of-test.
module gpout_console_arbiter #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SETUP_CYC  = 8'd2,
    parameter logic [7:0] STROBE_CYC = 8'd2,
    parameter logic [7:0] HOLD_CYC   = 8'd1
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [7:0]  CH_DATA,
    input  logic        CH_VALID,
    output logic        CH_READY,
    input  logic [7:0]  ST_CODE,
    input  logic        ST_VALID,
    output logic        ST_READY,
    output logic [15:0] GPOUT,
    output logic        DONE,
    output logic [15:0] TX_COUNT
);

    localparam int AW = $clog2(FIFO_DEPTH);

    // A zero phase length would collapse the handshake the display relies on, so it is stretched to one cycle.
    localparam logic [7:0] SETUP_EFF  = (SETUP_CYC  == 8'd0) ? 8'd1 : SETUP_CYC;
    localparam logic [7:0] STROBE_EFF = (STROBE_CYC == 8'd0) ? 8'd1 : STROBE_CYC;
    localparam logic [7:0] HOLD_EFF   = (HOLD_CYC   == 8'd0) ? 8'd1 : HOLD_CYC;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    logic [7:0]  r_fifo [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic        r_st_pending;
    logic [7:0]  r_st_reg;
    state_t      r_state;
    logic        r_last_st;
    logic        r_grant_st;
    logic [7:0]  r_cnt;
    logic [15:0] r_gpout;
    logic        r_done;
    logic [15:0] r_tx_count;
    logic        r_ch_rdy;
    logic        r_st_rdy;

    logic        w_push;
    logic        w_st_acc;
    logic        w_ch_pend;
    logic        w_pick_st;
    logic        w_grant;
    logic        w_pop;
    logic        w_st_clr;
    logic        w_hold_exit;
    logic        w_done_nxt;
    logic        w_st_pend_nxt;
    logic [AW:0] w_wr_nxt;
    logic [AW:0] w_rd_nxt;
    logic        w_full_nxt;

    assign w_push    = CH_VALID & r_ch_rdy;
    assign w_st_acc  = ST_VALID & r_st_rdy;
    assign w_ch_pend = (r_wr_ptr != r_rd_ptr);

    // On a tie the source that did not win last time goes next; a lone requester always wins.
    assign w_pick_st = r_st_pending & (~w_ch_pend | ~r_last_st);
    assign w_grant   = (r_state == S_IDLE) & (w_ch_pend | r_st_pending);
    assign w_pop     = w_grant & ~w_pick_st;
    assign w_st_clr  = w_grant & w_pick_st;

    assign w_hold_exit   = (r_state == S_HOLD) & (r_cnt == 8'd1);
    assign w_done_nxt    = r_done | (w_hold_exit & r_grant_st & (r_gpout[7:0] == 8'd1));
    assign w_st_pend_nxt = w_st_acc | (r_st_pending & ~w_st_clr);
    assign w_wr_nxt      = r_wr_ptr + (AW+1)'(w_push);
    assign w_rd_nxt      = r_rd_ptr + (AW+1)'(w_pop);
    assign w_full_nxt    = (w_wr_nxt[AW] != w_rd_nxt[AW]) && (w_wr_nxt[AW-1:0] == w_rd_nxt[AW-1:0]);

    assign CH_READY = r_ch_rdy;
    assign ST_READY = r_st_rdy;
    assign GPOUT    = r_gpout;
    assign DONE     = r_done;
    assign TX_COUNT = r_tx_count;

    // Character storage: written on an accepted push, never cleared (pointers define validity).
    always_ff @(posedge CLK) begin
        if (RSTn && w_push) begin
            r_fifo[r_wr_ptr[AW-1:0]] <= CH_DATA;
        end
    end

    // FIFO pointers: extra MSB distinguishes full from empty.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
        end
    end

    // Status holding register: one code outstanding at a time.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_st_pending <= 1'b0;
            r_st_reg     <= 8'd0;
        end else begin
            r_st_pending <= w_st_pend_nxt;
            if (w_st_acc) begin
                r_st_reg <= ST_CODE;
            end
        end
    end

    // Strobe sequencer: grant, data setup, strobe pulse, hold, then completion bookkeeping.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state    <= S_IDLE;
            r_last_st  <= 1'b0;
            r_grant_st <= 1'b0;
            r_cnt      <= 8'd0;
            r_gpout    <= 16'd0;
            r_done     <= 1'b0;
            r_tx_count <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_gpout[7:0] <= w_pick_st ? r_st_reg : r_fifo[r_rd_ptr[AW-1:0]];
                        r_gpout[8]   <= 1'b1;
                        r_grant_st   <= w_pick_st;
                        r_last_st    <= w_pick_st;
                        r_cnt        <= SETUP_EFF;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 8'd1) begin
                        r_gpout[9]  <= ~r_grant_st;
                        r_gpout[10] <= r_grant_st;
                        r_cnt       <= STROBE_EFF;
                        r_state     <= S_STROBE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == 8'd1) begin
                        r_gpout[10:9] <= 2'b00;
                        r_cnt         <= HOLD_EFF;
                        r_state       <= S_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == 8'd1) begin
                        r_gpout[8] <= 1'b0;
                        if (!r_grant_st) begin
                            r_tx_count <= r_tx_count + 16'd1;
                        end
                        if (r_grant_st && (r_gpout[7:0] == 8'd1)) begin
                            r_done  <= 1'b1;
                            r_state <= S_HALT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Ready flags are registered from next-cycle occupancy so they never depend on the current inputs.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_ch_rdy <= 1'b0;
            r_st_rdy <= 1'b0;
        end else begin
            r_ch_rdy <= ~w_full_nxt & ~w_done_nxt;
            r_st_rdy <= ~w_st_pend_nxt & ~w_done_nxt;
        end
    end

endmodule

// File: tb/tb_gpout_console_arbiter.sv
// Bench for gpout_console_arbiter: directed scenarios plus random traffic against a timeline model.
// Default instance u_dut (2/2/1 phases) and u_fast (0/0/0 phases, behaving as 1/1/1).
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
module tb_gpout_console_arbiter;

    localparam int DEPTH = 4;
    localparam int SS = 2;
    localparam int TT = 2;
    localparam int HH = 1;

    logic        CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        rst_n;
    logic [7:0]  ch_data;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  st_code;
    logic        st_valid;
    logic        st_ready;
    logic [15:0] gpout;
    logic        done;
    logic [15:0] tx_count;

    logic [7:0]  f_ch_data;
    logic        f_ch_valid;
    logic        f_ch_ready;
    logic [7:0]  f_st_code;
    logic        f_st_valid;
    logic        f_st_ready;
    logic [15:0] f_gpout;
    logic        f_done;
    logic [15:0] f_tx_count;

    gpout_console_arbiter #(.FIFO_DEPTH(DEPTH)) u_dut (
        .CLK(CLK), .RSTn(rst_n),
        .CH_DATA(ch_data), .CH_VALID(ch_valid), .CH_READY(ch_ready),
        .ST_CODE(st_code), .ST_VALID(st_valid), .ST_READY(st_ready),
        .GPOUT(gpout), .DONE(done), .TX_COUNT(tx_count)
    );

    gpout_console_arbiter #(.FIFO_DEPTH(DEPTH), .SETUP_CYC(8'd0), .STROBE_CYC(8'd0), .HOLD_CYC(8'd0)) u_fast (
        .CLK(CLK), .RSTn(rst_n),
        .CH_DATA(f_ch_data), .CH_VALID(f_ch_valid), .CH_READY(f_ch_ready),
        .ST_CODE(f_st_code), .ST_VALID(f_st_valid), .ST_READY(f_st_ready),
        .GPOUT(f_gpout), .DONE(f_done), .TX_COUNT(f_tx_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // strobe rising-edge log (kind 0 = char, 1 = status)
    int ev_kind [64];
    int ev_data [64];
    int ev_cyc  [64];
    int ev_n;
    int fev_data [64];
    int fev_cyc  [64];
    int fev_n;
    logic p9 = 1'b0, p10 = 1'b0, fp9 = 1'b0;

    // reference model: timeline of the transfer in flight
    logic [7:0]  mq[$];
    logic        m_st_pend, m_last, m_done, m_have, m_type, m_ch_rdy, m_st_rdy;
    logic [7:0]  m_st_code, m_code, m_data;
    logic [15:0] m_tx;
    int          m_g, m_next;

    task automatic clear_ev();
        for (int i = 0; i < 64; i++) begin
            ev_kind[i] = -1; ev_data[i] = -1; ev_cyc[i] = -1;
            fev_data[i] = -1; fev_cyc[i] = -1;
        end
        ev_n = 0;
        fev_n = 0;
    endtask

    task automatic model_edge();
        logic acc_c, acc_s, pick;
        if (!rst_n) begin
            mq.delete();
            m_st_pend = 0; m_st_code = 0; m_last = 0; m_done = 0; m_tx = 0;
            m_data = 0; m_have = 0; m_next = 0; m_ch_rdy = 0; m_st_rdy = 0;
            m_type = 0; m_code = 0; m_g = 0;
        end else begin
            acc_c = ch_valid && m_ch_rdy;
            acc_s = st_valid && m_st_rdy;
            if (m_have && cyc == m_g + SS + TT + HH) begin
                if (!m_type) m_tx = m_tx + 16'd1;
                else if (m_code == 8'd1) m_done = 1;
            end
            if (!m_done && cyc >= m_next && (mq.size() != 0 || m_st_pend)) begin
                pick = m_st_pend && (mq.size() == 0 || !m_last);
                if (pick) begin
                    m_data = m_st_code; m_code = m_st_code; m_st_pend = 0;
                end else begin
                    m_data = mq.pop_front();
                end
                m_type = pick; m_last = pick; m_g = cyc; m_have = 1;
                m_next = cyc + SS + TT + HH + 1;
            end
            if (acc_c) mq.push_back(ch_data);
            if (acc_s) begin m_st_pend = 1; m_st_code = st_code; end
            m_ch_rdy = !m_done && (mq.size() < DEPTH);
            m_st_rdy = !m_done && !m_st_pend;
        end
    endtask

    function automatic logic [15:0] exp_gpout();
        logic busy, s;
        busy = m_have && cyc >= m_g && cyc < m_g + SS + TT + HH;
        s    = m_have && cyc >= m_g + SS && cyc < m_g + SS + TT;
        return {5'b0, s && m_type, s && !m_type, busy, m_data};
    endfunction

    task automatic tick();
        @(posedge CLK);
        cyc++;
        model_edge();
        #1;
        if (gpout[9] && !p9 && ev_n < 64) begin
            ev_kind[ev_n] = 0; ev_data[ev_n] = int'(gpout[7:0]); ev_cyc[ev_n] = cyc; ev_n++;
        end
        if (gpout[10] && !p10 && ev_n < 64) begin
            ev_kind[ev_n] = 1; ev_data[ev_n] = int'(gpout[7:0]); ev_cyc[ev_n] = cyc; ev_n++;
        end
        if (f_gpout[9] && !fp9 && fev_n < 64) begin
            fev_data[fev_n] = int'(f_gpout[7:0]); fev_cyc[fev_n] = cyc; fev_n++;
        end
        p9 = gpout[9]; p10 = gpout[10]; fp9 = f_gpout[9];
    endtask

    task automatic do_reset();
        ch_valid = 0; st_valid = 0; f_ch_valid = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        clear_ev();
    endtask

    task automatic wait_ev(input int n, input int budget);
        for (int i = 0; i < budget && ev_n < n; i++) tick();
    endtask

    task automatic test_reset();
        rst_n = 0; ch_valid = 0; st_valid = 0; f_ch_valid = 0;
        tick(); tick();
        total++; if (gpout !== 16'h0) begin bad++; $display("FAIL reset_gpout got=%h exp=0000", gpout); end
        total++; if (ch_ready !== 1'b0) begin bad++; $display("FAIL reset_ch_ready got=%b exp=0", ch_ready); end
        total++; if (st_ready !== 1'b0) begin bad++; $display("FAIL reset_st_ready got=%b exp=0", st_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (tx_count !== 16'h0) begin bad++; $display("FAIL reset_tx got=%0d exp=0", tx_count); end
        rst_n = 1;
        tick();
        total++; if (ch_ready !== 1'b1) begin bad++; $display("FAIL release_ch_ready got=%b exp=1", ch_ready); end
        total++; if (st_ready !== 1'b1) begin bad++; $display("FAIL release_st_ready got=%b exp=1", st_ready); end
    endtask

    task automatic test_hi();
        int a0;
        do_reset();
        ch_data = 8'h48; ch_valid = 1;
        tick(); a0 = cyc;
        ch_data = 8'h69;
        tick(); ch_valid = 0;
        wait_ev(2, 60);
        for (int i = 0; i < 6; i++) tick();
        total++; if (ev_n != 2) begin bad++; $display("FAIL hi_count got=%0d exp=2", ev_n); end
        total++; if (ev_data[0] != 8'h48 || ev_kind[0] != 0) begin bad++; $display("FAIL hi_first got=%h/%0d exp=48/0", ev_data[0], ev_kind[0]); end
        total++; if (ev_data[1] != 8'h69 || ev_kind[1] != 0) begin bad++; $display("FAIL hi_second got=%h/%0d exp=69/0", ev_data[1], ev_kind[1]); end
        total++; if (ev_cyc[0] - a0 != 3) begin bad++; $display("FAIL hi_latency got=%0d exp=3", ev_cyc[0] - a0); end
        total++; if (ev_cyc[1] - ev_cyc[0] != 6) begin bad++; $display("FAIL hi_period got=%0d exp=6", ev_cyc[1] - ev_cyc[0]); end
        total++; if (tx_count !== 16'd2) begin bad++; $display("FAIL hi_tx got=%0d exp=2", tx_count); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ch_data = 8'hA0 + 8'(i); ch_valid = 1;
            for (int g = 0; g < 50 && !ch_ready; g++) tick();
            tick();
        end
        ch_valid = 0;
        total++; if (ch_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", ch_ready); end
        wait_ev(5, 100);
        for (int i = 0; i < 6; i++) tick();
        total++; if (ev_n != 5) begin bad++; $display("FAIL full_count got=%0d exp=5", ev_n); end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (ev_data[i] != 8'hA0 + i) begin bad++; $display("FAIL full_order[%0d] got=%h exp=%h", i, ev_data[i], 8'hA0 + i); end
        end
        total++; if (tx_count !== 16'd5) begin bad++; $display("FAIL full_tx got=%0d exp=5", tx_count); end
        total++; if (ch_ready !== 1'b1) begin bad++; $display("FAIL full_drain_ready got=%b exp=1", ch_ready); end
    endtask

    task automatic test_tie();
        int ek [4];
        int ed [4];
        ek = '{1, 0, 1, 0};
        ed = '{8'h07, 8'h41, 8'h09, 8'h42};
        do_reset();
        ch_data = 8'h41; ch_valid = 1; st_code = 8'h07; st_valid = 1;
        tick();
        ch_valid = 0; st_valid = 0;
        wait_ev(1, 30);
        ch_data = 8'h42; ch_valid = 1; st_code = 8'h09; st_valid = 1;
        tick();
        ch_valid = 0; st_valid = 0;
        wait_ev(4, 100);
        total++; if (ev_n != 4) begin bad++; $display("FAIL tie_count got=%0d exp=4", ev_n); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (ev_kind[i] != ek[i] || ev_data[i] != ed[i]) begin
                bad++; $display("FAIL tie_seq[%0d] got=%0d/%h exp=%0d/%h", i, ev_kind[i], ev_data[i], ek[i], ed[i]);
            end
        end
    endtask

    task automatic test_done();
        do_reset();
        ch_data = 8'h70; ch_valid = 1; st_code = 8'h01; st_valid = 1;
        tick();
        st_valid = 0; ch_data = 8'h71;
        tick();
        ch_valid = 0;
        for (int i = 0; i < 40; i++) tick();
        total++; if (ev_n != 1) begin bad++; $display("FAIL done_events got=%0d exp=1", ev_n); end
        total++; if (ev_kind[0] != 1 || ev_data[0] != 8'h01) begin bad++; $display("FAIL done_strobe got=%0d/%h exp=1/01", ev_kind[0], ev_data[0]); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL done_flag got=%b exp=1", done); end
        total++; if (ch_ready !== 1'b0 || st_ready !== 1'b0) begin bad++; $display("FAIL done_ready got=%b%b exp=00", ch_ready, st_ready); end
        total++; if (tx_count !== 16'd0) begin bad++; $display("FAIL done_tx got=%0d exp=0", tx_count); end
        total++; if (gpout[10:8] !== 3'b000) begin bad++; $display("FAIL done_bus got=%b exp=000", gpout[10:8]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        ch_valid = 1;
        for (int i = 0; i < 3; i++) begin ch_data = 8'h31 + 8'(i); tick(); end
        ch_valid = 0;
        for (int i = 0; i < 30 && !gpout[9]; i++) tick();
        total++; if (gpout[9] !== 1'b1) begin bad++; $display("FAIL mid_strobe got=%b exp=1", gpout[9]); end
        rst_n = 0;
        tick();
        total++; if (gpout !== 16'h0) begin bad++; $display("FAIL mid_gpout got=%h exp=0000", gpout); end
        total++; if (tx_count !== 16'h0) begin bad++; $display("FAIL mid_tx got=%0d exp=0", tx_count); end
        rst_n = 1;
        tick();
        clear_ev();
        for (int i = 0; i < 20; i++) tick();
        total++; if (ev_n != 0) begin bad++; $display("FAIL mid_fifo_flushed got=%0d exp=0", ev_n); end
        ch_data = 8'h5A; ch_valid = 1;
        tick();
        ch_valid = 0;
        wait_ev(1, 30);
        for (int i = 0; i < 5; i++) tick();
        total++; if (ev_data[0] != 8'h5A) begin bad++; $display("FAIL mid_after got=%h exp=5a", ev_data[0]); end
        total++; if (tx_count !== 16'd1) begin bad++; $display("FAIL mid_after_tx got=%0d exp=1", tx_count); end
    endtask

    task automatic test_zero_cyc();
        int a0;
        do_reset();
        f_ch_data = 8'h11; f_ch_valid = 1;
        tick(); a0 = cyc;
        f_ch_data = 8'h22;
        tick(); f_ch_valid = 0;
        for (int i = 0; i < 40 && fev_n < 2; i++) tick();
        for (int i = 0; i < 4; i++) tick();
        total++; if (fev_cyc[0] - a0 != 2) begin bad++; $display("FAIL zero_latency got=%0d exp=2", fev_cyc[0] - a0); end
        total++; if (fev_cyc[1] - fev_cyc[0] != 4) begin bad++; $display("FAIL zero_period got=%0d exp=4", fev_cyc[1] - fev_cyc[0]); end
        total++; if (fev_data[0] != 8'h11 || fev_data[1] != 8'h22) begin bad++; $display("FAIL zero_data got=%h,%h exp=11,22", fev_data[0], fev_data[1]); end
        total++; if (f_tx_count !== 16'd2) begin bad++; $display("FAIL zero_tx got=%0d exp=2", f_tx_count); end
        total++; if (f_done !== 1'b0 || f_st_ready !== 1'b1) begin bad++; $display("FAIL zero_flags got=%b%b exp=01", f_done, f_st_ready); end
    endtask

    task automatic test_random();
        logic [15:0] eg;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ch_valid = ($urandom_range(0, 99) < 40);
            ch_data  = 8'($urandom);
            st_valid = ($urandom_range(0, 99) < 12);
            st_code  = 8'($urandom);
            if (st_code == 8'd1) st_code = 8'd2;
            rst_n    = ($urandom_range(0, 499) != 0);
            tick();
            eg = exp_gpout();
            total++; if (gpout !== eg) begin bad++; $display("FAIL rnd_gpout cyc=%0d got=%h exp=%h", cyc, gpout, eg); end
            total++; if (ch_ready !== m_ch_rdy) begin bad++; $display("FAIL rnd_ch_ready cyc=%0d got=%b exp=%b", cyc, ch_ready, m_ch_rdy); end
            total++; if (st_ready !== m_st_rdy) begin bad++; $display("FAIL rnd_st_ready cyc=%0d got=%b exp=%b", cyc, st_ready, m_st_rdy); end
            total++; if (done !== m_done) begin bad++; $display("FAIL rnd_done cyc=%0d got=%b exp=%b", cyc, done, m_done); end
            total++; if (tx_count !== m_tx) begin bad++; $display("FAIL rnd_tx cyc=%0d got=%0d exp=%0d", cyc, tx_count, m_tx); end
        end
        rst_n = 1; ch_valid = 0; st_valid = 0;
    endtask

    initial begin
        rst_n = 0;
        ch_data = 0; ch_valid = 0; st_code = 0; st_valid = 0;
        f_ch_data = 0; f_ch_valid = 0; f_st_code = 0; f_st_valid = 0;
        clear_ev();
        test_reset();
        test_hi();
        test_fifo_full();
        test_tie();
        test_done();
        test_reset_mid();
        test_zero_cyc();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
